// File: rtl/leon_arb_pkg.sv
// Shared types and constants for the LEON memory arbiter.
package leon_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IC_ACC = 2'd1,
    DC_ACC = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_IC = 1'b0,
    GNT_DC = 1'b1
  } grant_e;

  // SPARC "sethi 0,%g0": returned to the fetch path when a fetch times out
  localparam logic [31:0] NOP_INST = 32'h01000000;

endpackage

// File: rtl/leon_arb_prio.sv
// Grant selection between icache and dcache, with a starvation counter
// that forces an icache grant after STARVE_MAX back-to-back dcache grants.
module leon_arb_prio
  import leon_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   ic_req,
  input  logic   dc_req,
  input  logic   arb_en,
  output logic   gnt_vld,
  output grant_e gnt
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == CW'(STARVE_MAX));

  // Data side wins ties unless the fetch side has waited STARVE_MAX grants
  always_comb begin
    gnt_vld = arb_en && (ic_req || dc_req);
    gnt     = GNT_DC;
    if (ic_req && (!dc_req || starved))
      gnt = GNT_IC;
  end

  // Count dcache grants taken while a fetch is waiting; saturate at the limit
  always_ff @(posedge clk) begin
    if (!rst)
      starve_cnt <= '0;
    else if (!ic_req)
      starve_cnt <= '0;
    else if (gnt_vld) begin
      if (gnt == GNT_IC)
        starve_cnt <= '0;
      else if (!starved)
        starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/leon_mem_arbiter.sv
// Shares one memory port between LEON instruction fetch and data access.
// Optional feature: define ARB_TIMEOUT_EN to abort accesses that see no
// mem_ack within TIMEOUT_CYC cycles (fetch returns a nop, data raises mexc).
module leon_mem_arbiter
  import leon_arb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ic_req,
  input  logic [AW-1:0] ic_addr,
  output logic [DW-1:0] ic_rdata,
  output logic          ic_hold,
  output logic          ic_mds,
  input  logic          dc_req,
  input  logic          dc_we,
  input  logic [AW-1:0] dc_addr,
  input  logic [DW-1:0] dc_wdata,
  output logic [DW-1:0] dc_rdata,
  output logic          dc_hold,
  output logic          dc_mds,
  output logic          dc_mexc,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  arb_state_e state, state_nxt;
  grant_e     gnt, gnt_q;
  logic       gnt_vld;
  logic       in_acc;
  logic       tmo_hit;
  logic       resp_ic, resp_dc;

  leon_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk     (clk),
    .rst     (rst),
    .ic_req  (ic_req),
    .dc_req  (dc_req),
    .arb_en  (state == IDLE),
    .gnt_vld (gnt_vld),
    .gnt     (gnt)
  );

  assign in_acc  = (state == IC_ACC) || (state == DC_ACC);
  assign resp_ic = (state == RESP) && (gnt_q == GNT_IC);
  assign resp_dc = (state == RESP) && (gnt_q == GNT_DC);

  // Holds are combinational so the core stalls in the same cycle it requests
  assign ic_hold = !(rst && ic_req && !resp_ic);
  assign dc_hold = !(rst && dc_req && !resp_dc);
  assign ic_mds  = !resp_ic;
  assign dc_mds  = !resp_dc;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          mexc_q;

  assign tmo_hit = in_acc && !mem_ack && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign dc_mexc = resp_dc && mexc_q;

  // Cycles spent waiting in the current access; cleared outside *_ACC
  always_ff @(posedge clk) begin
    if (!rst || !in_acc)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + TW'(1);
  end

  // Error flag for the data side, presented only during its RESP cycle
  always_ff @(posedge clk) begin
    if (!rst)
      mexc_q <= 1'b0;
    else if (state == IDLE)
      mexc_q <= 1'b0;
    else if (state == DC_ACC && tmo_hit)
      mexc_q <= 1'b1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC > 0);
  assign tmo_hit    = 1'b0;
  assign dc_mexc    = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state: grant from IDLE, wait for ack, one strobe cycle, back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:           if (gnt_vld) state_nxt = (gnt == GNT_IC) ? IC_ACC : DC_ACC;
      IC_ACC, DC_ACC: if (mem_ack || tmo_hit) state_nxt = RESP;
      RESP:           state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  // Memory-side request registers and core-side read data capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_q     <= GNT_IC;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ic_rdata  <= '0;
      dc_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            gnt_q   <= gnt;
            mem_req <= 1'b1;
            if (gnt == GNT_IC) begin
              mem_addr <= ic_addr;
              mem_we   <= 1'b0;
            end else begin
              mem_addr  <= dc_addr;
              mem_we    <= dc_we;
              mem_wdata <= dc_wdata;
            end
          end
        end
        IC_ACC: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            ic_rdata <= mem_rdata;
          end else if (tmo_hit) begin
            mem_req  <= 1'b0;
            ic_rdata <= DW'(NOP_INST);
          end
        end
        DC_ACC: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we)
              dc_rdata <= mem_rdata;
          end else if (tmo_hit) begin
            mem_req  <= 1'b0;
            dc_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_leon_mem_arbiter.sv
// Directed bench for leon_mem_arbiter (default build; ARB_TIMEOUT_EN selects
// the timeout expectations).
module tb_leon_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic [31:0] ic_rdata;
  logic        ic_hold, ic_mds;
  logic        dc_req, dc_we;
  logic [31:0] dc_addr, dc_wdata, dc_rdata;
  logic        dc_hold, dc_mds, dc_mexc;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;

  int tests = 0;
  int fails = 0;

  leon_mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_rdata  (ic_rdata),
    .ic_hold   (ic_hold),
    .ic_mds    (ic_mds),
    .dc_req    (dc_req),
    .dc_we     (dc_we),
    .dc_addr   (dc_addr),
    .dc_wdata  (dc_wdata),
    .dc_rdata  (dc_rdata),
    .dc_hold   (dc_hold),
    .dc_mds    (dc_mds),
    .dc_mexc   (dc_mexc),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       seen;
    logic       is_ic;
    int         waited;
    logic [5:0] exp_ic;

    rst = 1'b0; ic_req = 1'b1; ic_addr = 32'h200;
    dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;

    // Reset with a fetch already pending
    step(); step();
    chk("rst_mem_req",  {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we",   {31'b0, mem_we},  32'd0);
    chk("rst_mem_addr", mem_addr,         32'd0);
    chk("rst_ic_hold",  {31'b0, ic_hold}, 32'd1);
    chk("rst_dc_hold",  {31'b0, dc_hold}, 32'd1);
    chk("rst_ic_mds",   {31'b0, ic_mds},  32'd1);
    chk("rst_dc_mds",   {31'b0, dc_mds},  32'd1);
    chk("rst_dc_mexc",  {31'b0, dc_mexc}, 32'd0);
    chk("rst_ic_rdata", ic_rdata,         32'd0);
    chk("rst_dc_rdata", dc_rdata,         32'd0);

    rst = 1'b1; #1;
    chk("post_rst_ic_hold", {31'b0, ic_hold}, 32'd0);
    step();
    chk("first_gnt_req",  {31'b0, mem_req}, 32'd1);
    chk("first_gnt_addr", mem_addr,         32'h200);
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    step();
    mem_ack = 1'b0;
    chk("first_mds", {31'b0, ic_mds}, 32'd0);
    ic_req = 1'b0;
    step();

    // Stray ack in IDLE must not start anything
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("idle_ack_req",    {31'b0, mem_req}, 32'd0);
    chk("idle_ack_ic_mds", {31'b0, ic_mds},  32'd1);
    chk("idle_ack_dc_mds", {31'b0, dc_mds},  32'd1);

    // Single fetch, ack in first ACC cycle: strobe in the third cycle
    ic_req = 1'b1; ic_addr = 32'h40; #1;
    chk("fetch_hold_c1", {31'b0, ic_hold}, 32'd0);
    step();
    chk("fetch_mem_req",  {31'b0, mem_req}, 32'd1);
    chk("fetch_mem_addr", mem_addr,         32'h40);
    chk("fetch_mds_c2",   {31'b0, ic_mds},  32'd1);
    chk("fetch_hold_c2",  {31'b0, ic_hold}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h8E00C002;
    step();
    mem_ack = 1'b0;
    chk("fetch_mds_c3",  {31'b0, ic_mds},  32'd0);
    chk("fetch_hold_c3", {31'b0, ic_hold}, 32'd1);
    chk("fetch_rdata",   ic_rdata,         32'h8E00C002);
    chk("fetch_req_off", {31'b0, mem_req}, 32'd0);
    ic_req = 1'b0;
    step();
    chk("fetch_mds_c4", {31'b0, ic_mds}, 32'd1);

    // Load to give dc_rdata a known value
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h80;
    step();
    chk("load_we",   {31'b0, mem_we}, 32'd0);
    chk("load_addr", mem_addr,        32'h80);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE0001;
    step();
    mem_ack = 1'b0;
    chk("load_mds",   {31'b0, dc_mds}, 32'd0);
    chk("load_rdata", dc_rdata,        32'hCAFE0001);
    dc_req = 1'b0;
    step();

    // Store with one wait cycle; dc_rdata must keep the loaded value
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h100; dc_wdata = 32'h13;
    step();
    chk("store_req",   {31'b0, mem_req}, 32'd1);
    chk("store_we",    {31'b0, mem_we},  32'd1);
    chk("store_addr",  mem_addr,         32'h100);
    chk("store_wdata", mem_wdata,        32'h13);
    dc_wdata = 32'hFFFF;
    step();
    chk("store_wait_req",   {31'b0, mem_req}, 32'd1);
    chk("store_wait_wdata", mem_wdata,        32'h13);
    chk("store_wait_mds",   {31'b0, dc_mds},  32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_ack = 1'b0;
    chk("store_mds",   {31'b0, dc_mds},  32'd0);
    chk("store_hold",  {31'b0, dc_hold}, 32'd1);
    chk("store_mexc",  {31'b0, dc_mexc}, 32'd0);
    chk("store_rdata", dc_rdata,         32'hCAFE0001);
    dc_req = 1'b0; dc_we = 1'b0;
    step();
    chk("store_mds_end", {31'b0, dc_mds}, 32'd1);

    // Requester withdraws mid-access: strobe still issued
    dc_req = 1'b1; dc_addr = 32'h44;
    step();
    dc_req = 1'b0;
    step();
    mem_ack = 1'b1; mem_rdata = 32'h55;
    step();
    mem_ack = 1'b0;
    chk("drop_mds",   {31'b0, dc_mds}, 32'd0);
    chk("drop_rdata", dc_rdata,        32'h55);
    step();

    // Contention: expect DC,DC,DC,DC,IC,DC (bit i = grant i is icache)
    exp_ic = 6'b010000;
    ic_req = 1'b1; ic_addr = 32'h1000;
    dc_req = 1'b1; dc_addr = 32'h2000;
    for (int g = 0; g < 6; g++) begin
      seen = 1'b0;
      for (int w = 0; w < 5 && !seen; w++) begin
        step();
        seen = mem_req;
      end
      chk($sformatf("cont_req_%0d", g), {31'b0, seen}, 32'd1);
      is_ic = (mem_addr == 32'h1000);
      chk($sformatf("cont_gnt_%0d", g), {31'b0, is_ic}, {31'b0, exp_ic[g]});
      mem_ack = 1'b1; mem_rdata = 32'hA0 + g;
      step();
      mem_ack = 1'b0;
      if (exp_ic[g])
        chk($sformatf("cont_mds_%0d", g), {31'b0, ic_mds}, 32'd0);
      else
        chk($sformatf("cont_mds_%0d", g), {31'b0, dc_mds}, 32'd0);
    end
    ic_req = 1'b0; dc_req = 1'b0;
    step();

    // Reset during DC_ACC, then a late ack
    dc_req = 1'b1; dc_addr = 32'h300;
    step();
    chk("mrst_req_on", {31'b0, mem_req}, 32'd1);
    rst = 1'b0;
    step();
    chk("mrst_req_off", {31'b0, mem_req}, 32'd0);
    rst = 1'b1; dc_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h99;
    step();
    mem_ack = 1'b0;
    chk("mrst_no_mds",   {31'b0, dc_mds},  32'd1);
    chk("mrst_req_idle", {31'b0, mem_req}, 32'd0);
    chk("mrst_rdata",    dc_rdata,         32'd0);
    ic_req = 1'b1; ic_addr = 32'h4;
    step();
    chk("mrst_idle_gnt",  {31'b0, mem_req}, 32'd1);
    chk("mrst_idle_addr", mem_addr,         32'h4);
    mem_ack = 1'b1; mem_rdata = 32'h7;
    step();
    mem_ack = 1'b0; ic_req = 1'b0;
    step();

    // Data load that never sees an ack
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h500;
    step();
`ifdef ARB_TIMEOUT_EN
    waited = 0;
    seen = 1'b0;
    while (!seen && waited < 80) begin
      step();
      waited++;
      seen = !dc_mds;
    end
    chk("tmo_cycles", waited,           32'd64);
    chk("tmo_mexc",   {31'b0, dc_mexc}, 32'd1);
    chk("tmo_rdata",  dc_rdata,         32'd0);
    chk("tmo_req",    {31'b0, mem_req}, 32'd0);
    dc_req = 1'b0;
    step();
`else
    waited = 0;
    repeat (70) begin
      step();
      waited++;
    end
    chk("wait_cycles", waited,           32'd70);
    chk("wait_req",    {31'b0, mem_req}, 32'd1);
    chk("wait_addr",   mem_addr,         32'h500);
    chk("wait_mds",    {31'b0, dc_mds},  32'd1);
    chk("wait_mexc",   {31'b0, dc_mexc}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h77;
    step();
    mem_ack = 1'b0;
    chk("wait_done_mds",   {31'b0, dc_mds}, 32'd0);
    chk("wait_done_rdata", dc_rdata,        32'h77);
    dc_req = 1'b0;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/leon_mem_arbiter.md
Name: leon_mem_arbiter

Overview:
- Shares one backing memory port between the LEON integer unit's instruction-fetch path and data-access path.
- Sequences each access and drives the core-side hold and data strobes, replacing testbench-driven icache/dcache output values with a synthesizable responder.
- Sits between the core's icache/dcache request signals and a single-ported memory model or bus bridge.

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_MAX, 4, maximum consecutive dcache grants while an icache request waits
TIMEOUT_CYC, 64, cycles to wait for mem_ack before aborting (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
ic_req  in  1  instruction fetch request; level, held until served
ic_addr  in  AW  fetch address
ic_rdata  out  DW  fetched instruction
ic_hold  out  1  active-low stall to core; 0 while a fetch is pending
ic_mds  out  1  active-low strobe; 0 for one cycle when ic_rdata is valid
dc_req  in  1  data access request; level, held until served
dc_we  in  1  1 = store, 0 = load
dc_addr  in  AW  data address
dc_wdata  in  DW  store data
dc_rdata  out  DW  load data
dc_hold  out  1  active-low stall to core
dc_mds  out  1  active-low strobe; 0 for one cycle when dc_rdata is valid or a store completes
dc_mexc  out  1  memory exception; valid alongside dc_mds
mem_req  out  1  memory request; held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data; valid with mem_ack
mem_ack  in  1  one-cycle completion from memory

Behaviour:
- Reset values (rst=0 at posedge): FSM IDLE, starvation counter 0. Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ic_hold=1, dc_hold=1, ic_mds=1, dc_mds=1, dc_mexc=0, ic_rdata=0, dc_rdata=0.
- Reset mid-access: abandons the access and deasserts mem_req on the next edge. A late mem_ack after reset is ignored.
- FSM states:
  - IDLE: grant decision.
  - IC_ACC: wait for mem_ack on a fetch.
  - DC_ACC: wait for mem_ack on a data access.
  - RESP: one cycle that presents the strobe.
- Hold generation: ic_hold=0 combinationally whenever ic_req=1 and that requester is not in RESP. dc_hold follows the same rule for dc_req.
- Arbitration in IDLE:
  - Only dc_req: grant dcache.
  - Only ic_req: grant icache.
  - Both: grant dcache unless starve_cnt==STARVE_MAX, in which case grant icache.
  - starve_cnt increments on each dcache grant while ic_req=1. It clears on an icache grant or whenever ic_req=0. It saturates at STARVE_MAX.
- Grant cycle: latches the address (and for dcache, dc_we and dc_wdata) into mem_* registers and sets mem_req=1 on the same edge as the IDLE→*_ACC transition.
- *_ACC: mem_req and mem_* stay stable until mem_ack=1. On mem_ack:
  - capture mem_rdata into ic_rdata or dc_rdata (stores leave dc_rdata unchanged);
  - drop mem_req;
  - go to RESP.
- RESP:
  - Drive the granted side's mds=0 and hold=1 for exactly one cycle.
  - Return to IDLE.
  - Minimum latency from req to mds is 3 cycles with mem_ack in the first ACC cycle.
- Back-to-back: the next arbitration happens in the IDLE cycle after RESP. There is no combinational grant from RESP.
- mem_ack in IDLE or RESP is ignored.
- Requester drops req mid-access: the access completes and the strobe is still issued.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in *_ACC.
  - If TIMEOUT_CYC cycles elapse without mem_ack, drop mem_req and go to RESP.
  - A dcache access then raises dc_mexc=1 with dc_mds=0 and dc_rdata=0.
  - An icache access returns ic_rdata=32'h01000000 (nop).
- Undefined: *_ACC waits indefinitely, and dc_mexc stays tied to 0.

Decomposition:
- Package leon_arb_pkg holds:
  - arb_state_e enum (IDLE, IC_ACC, DC_ACC, RESP);
  - grant_e enum (GNT_IC, GNT_DC);
  - NOP_INST = 32'h01000000.
- One sub-module, leon_arb_prio: combinational grant plus the starvation counter register. The FSM and datapath stay in the top module.

Test Plan:
- Reset: drive rst=0 for 2 cycles with ic_req=1 → mem_req=0, ic_hold=1, all mds=1. After release, the first grant is icache with mem_addr=ic_addr.
- Single fetch: ic_addr=0x40, mem_ack on the 1st ACC cycle with mem_rdata=0x8E00C002 → ic_mds=0 exactly 3 cycles after ic_req, ic_rdata=0x8E00C002, ic_hold=0 until then.
- Store: dc_we=1, dc_addr=0x100, dc_wdata=0x13 → mem_we=1, mem_addr=0x100, mem_wdata=0x13, then dc_mds=0 for one cycle with dc_rdata unchanged.
- Contention: ic_req and dc_req held continuously, ack latency 1 → grant order DC,DC,DC,DC,IC,DC… (STARVE_MAX=4).
- Reset mid-access: rst=0 in DC_ACC, then mem_ack arrives → no dc_mds, FSM in IDLE, mem_req=0.
- With ARB_TIMEOUT_EN: a dcache load with no mem_ack → after 64 cycles dc_mds=0, dc_mexc=1, dc_rdata=0.
